// File: rtl/csa_serial_accum_pkg.sv
// Shared constants and state encoding for the byte-serial carry-save accumulator.
// The default sizes keep N_OPS*(2^DATA_W-1) inside SUM_W, so carries never fall off the top.
package csa_pkg;
    localparam int CSA_DATA_W = 8;
    localparam int CSA_SUM_W  = 18;
    localparam int CSA_N_OPS  = 10;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int cnt_width(input int n_ops);
        return $clog2(n_ops + 1);
    endfunction
endpackage

// File: rtl/csa_serial_accum_if.sv
// Operand-in / result-out handshake bundle for csa_serial_accum.
// The slave side is the accumulator; the master side is the source plus the consumer.
interface csa_serial_accum_if
    import csa_pkg::*;
#(
    parameter int DATA_W = CSA_DATA_W,
    parameter int SUM_W  = CSA_SUM_W,
    parameter int N_OPS  = CSA_N_OPS,
    parameter int CNT_W  = cnt_width(N_OPS)
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [CNT_W-1:0]  op_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, op_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, op_count
    );
endinterface

// File: rtl/csa_serial_accum_3to2.sv
// Bitwise 3:2 compressor: sum is the XOR, carry is the majority shifted up one place.
// The bit shifted out of the top is dropped; the width rule guarantees it is zero.
module csa_3to2 #(
    parameter int W = 18
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] x,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);
    logic [W-1:0] maj;

    assign sum   = a ^ b ^ x;
    assign maj   = (a & b) | (a & x) | (b & x);
    assign carry = {maj[W-2:0], 1'b0};
endmodule

// File: rtl/csa_serial_accum.sv
// Folds one byte per handshake into a redundant sum/carry pair, then spends one
// cycle on a carry-propagate add and holds the total until the consumer takes it.
module csa_serial_accum
    import csa_pkg::*;
#(
    parameter int N_OPS  = CSA_N_OPS,
    parameter int DATA_W = CSA_DATA_W,
    parameter int SUM_W  = CSA_SUM_W,
    parameter int CNT_W  = cnt_width(N_OPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    csa_serial_accum_if.slave bus
);
    state_t             state;
    logic [SUM_W-1:0]   s_reg;
    logic [SUM_W-1:0]   c_reg;
    logic [SUM_W-1:0]   s_nxt;
    logic [SUM_W-1:0]   c_nxt;
    logic [SUM_W-1:0]   sum_reg;
    logic [CNT_W-1:0]   cnt;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               accept;

    assign accept = bus.in_valid && in_ready_reg;

    csa_3to2 #(.W(SUM_W)) u_csa (
        .a     (s_reg),
        .b     (c_reg),
        .x     (SUM_W'(bus.in_data)),
        .sum   (s_nxt),
        .carry (c_nxt)
    );

    // in_ready/out_valid are registered alongside the state so they change
    // on exactly the edges that move the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACCUM;
            s_reg         <= '0;
            c_reg         <= '0;
            sum_reg       <= '0;
            cnt           <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        s_reg <= s_nxt;
                        c_reg <= c_nxt;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(N_OPS - 1)) begin
                            state        <= RESOLVE;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    sum_reg       <= s_reg + c_reg;
                    s_reg         <= '0;
                    c_reg         <= '0;
                    out_valid_reg <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        cnt           <= '0;
                        state         <= ACCUM;
                    end
                end
                default: begin
                    state         <= ACCUM;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = sum_reg;
    assign bus.op_count  = cnt;
endmodule

// File: tb/tb_csa_serial_accum.sv
// Self-checking bench for csa_serial_accum: directed groups from the test plan plus
// random groups, all checked against a plain integer-sum reference model.
module tb_csa_serial_accum;
    localparam int N = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_serial_accum_if bus ();

    csa_serial_accum dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    typedef logic [7:0] ops_t [N];

    // Reference: the result is just the arithmetic total, wrapped to 18 bits.
    function automatic logic [17:0] ref_sum(input ops_t ops);
        int t = 0;
        for (int i = 0; i < N; i++) t += int'(ops[i]);
        return 18'(t);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until it is taken; ok=0 if never accepted.
    task automatic push(input logic [7:0] v, output bit ok);
        int n = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        while (!bus.in_ready && n < 40) begin
            step();
            n++;
        end
        if (bus.in_ready) begin
            step();
            ok = 1'b1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_group(input ops_t ops, input int maxgap, output int nok);
        bit ok;
        nok = 0;
        for (int i = 0; i < N; i++) begin
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) step();
            push(ops[i], ok);
            if (ok) nok++;
        end
    endtask

    // Wait for out_valid (bounded), capture out_sum, then complete the handshake.
    task automatic get_result(input int ready_delay, output logic [17:0] sum, output bit ok);
        int n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        ok  = bus.out_valid;
        sum = bus.out_sum;
        if (ok) begin
            repeat (ready_delay) step();
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (bus.op_count !== 4'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sum !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_state got cnt=%0d ov=%b ir=%b sum=%0d want 0/0/1/0",
                     bus.op_count, bus.out_valid, bus.in_ready, bus.out_sum);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_consecutive();
        ops_t ops = '{8'd11, 8'd2, 8'd13, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
        int nok;
        bus.out_ready = 1'b1;
        send_group(ops, 0, nok);
        // Just after the 10th accept: in RESOLVE, nothing valid yet, no more input taken.
        tests_run++;
        if (nok !== N || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.op_count !== 4'd10) begin
            tests_failed++;
            $display("FAIL consec_resolve got acc=%0d ov=%b ir=%b cnt=%0d want 10/0/0/10",
                     nok, bus.out_valid, bus.in_ready, bus.op_count);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 18'd75) begin
            tests_failed++;
            $display("FAIL consec_result got ov=%b sum=%0d want 1/75", bus.out_valid, bus.out_sum);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.op_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL consec_one_cycle got ov=%b ir=%b cnt=%0d want 0/1/0",
                     bus.out_valid, bus.in_ready, bus.op_count);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_gaps();
        ops_t ops = '{8'd3, 8'd14, 8'd5, 8'd6, 8'd7, 8'd8, 8'd19, 8'd10, 8'd0, 8'd0};
        int cnt_errs = 0;
        bit ok;
        logic [17:0] sum;
        for (int i = 0; i < N; i++) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
            if (bus.op_count !== 4'(i)) cnt_errs++;
            push(ops[i], ok);
            if (!ok || bus.op_count !== 4'(i + 1)) cnt_errs++;
        end
        tests_run++;
        if (cnt_errs !== 0) begin
            tests_failed++;
            $display("FAIL gaps_op_count got %0d tracking errors want 0", cnt_errs);
        end
        get_result(0, sum, ok);
        tests_run++;
        if (!ok || sum !== 18'd72) begin
            tests_failed++;
            $display("FAIL gaps_sum got ok=%b sum=%0d want 1/72", ok, sum);
        end
    endtask

    task automatic test_mixed();
        ops_t ops = '{8'd30, 8'd22, 8'd19, 8'd126, 8'd5, 8'd92, 8'd69, 8'd44, 8'd1, 8'd10};
        int nok;
        bit ok;
        logic [17:0] sum;
        send_group(ops, 0, nok);
        get_result(1, sum, ok);
        tests_run++;
        if (!ok || nok !== N || sum !== 18'd418) begin
            tests_failed++;
            $display("FAIL mixed_sum got ok=%b acc=%0d sum=%0d want 1/10/418", ok, nok, sum);
        end
    endtask

    task automatic test_back_to_back();
        ops_t big;
        ops_t ones;
        int nok;
        int n;
        for (int i = 0; i < N; i++) begin
            big[i]  = (i == N - 1) ? 8'd254 : 8'd255;
            ones[i] = 8'd1;
        end
        bus.out_ready = 1'b1;
        send_group(big, 0, nok);
        n = 0;
        while (!bus.out_valid && n < 10) begin step(); n++; end
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 18'd2549) begin
            tests_failed++;
            $display("FAIL b2b_max_sum got ov=%b sum=%0d want 1/2549", bus.out_valid, bus.out_sum);
        end
        send_group(ones, 0, nok);
        n = 0;
        while (!bus.out_valid && n < 10) begin step(); n++; end
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 18'd10) begin
            tests_failed++;
            $display("FAIL b2b_cleared_sum got ov=%b sum=%0d want 1/10", bus.out_valid, bus.out_sum);
        end
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        ops_t ops;
        ops_t rest;
        int nok;
        int errs = 0;
        bit ok;
        int n = 0;
        logic [17:0] exp;
        logic [17:0] sum;
        for (int i = 0; i < N; i++) ops[i] = 8'($urandom_range(0, 255));
        exp = ref_sum(ops);
        send_group(ops, 0, nok);
        while (!bus.out_valid && n < 10) begin step(); n++; end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_sum !== exp) errs++;
            step();
        end
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("FAIL bp_hold got %0d bad cycles (sum=%0d) want 0 (sum=%0d)", errs, bus.out_sum, exp);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.op_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL bp_handshake got ov=%b ir=%b cnt=%0d want 0/1/0",
                     bus.out_valid, bus.in_ready, bus.op_count);
        end
        step();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.op_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL bp_first_accept got cnt=%0d want 1", bus.op_count);
        end
        rest[0] = 8'hFF;
        for (int i = 1; i < N; i++) begin
            rest[i] = 8'($urandom_range(0, 255));
            push(rest[i], ok);
        end
        get_result(0, sum, ok);
        tests_run++;
        if (!ok || sum !== ref_sum(rest)) begin
            tests_failed++;
            $display("FAIL bp_next_sum got ok=%b sum=%0d want 1/%0d", ok, sum, ref_sum(rest));
        end
    endtask

    task automatic test_reset_mid_group();
        ops_t sevens;
        ops_t ops;
        int nok;
        bit ok;
        int n = 0;
        logic [17:0] sum;
        for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)), ok);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.op_count !== 4'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_group got cnt=%0d ov=%b ir=%b want 0/0/1",
                     bus.op_count, bus.out_valid, bus.in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        // Reset while a result is pending must drop out_valid at once.
        for (int i = 0; i < N; i++) ops[i] = 8'($urandom_range(1, 255));
        send_group(ops, 0, nok);
        while (!bus.out_valid && n < 10) begin step(); n++; end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== 18'd0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_done got ov=%b sum=%0d ir=%b want 0/0/1", bus.out_valid, bus.out_sum, bus.in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        for (int i = 0; i < N; i++) sevens[i] = 8'd7;
        send_group(sevens, 1, nok);
        get_result(0, sum, ok);
        tests_run++;
        if (!ok || sum !== 18'd70) begin
            tests_failed++;
            $display("FAIL rst_fresh_sum got ok=%b sum=%0d want 1/70", ok, sum);
        end
    endtask

    task automatic test_random();
        ops_t ops;
        int nok;
        bit ok;
        logic [17:0] sum;
        for (int g = 0; g < 6; g++) begin
            for (int i = 0; i < N; i++) ops[i] = 8'($urandom_range(0, 255));
            send_group(ops, 2, nok);
            get_result($urandom_range(0, 3), sum, ok);
            tests_run++;
            if (!ok || nok !== N || sum !== ref_sum(ops)) begin
                tests_failed++;
                $display("FAIL random_group%0d got ok=%b acc=%0d sum=%0d want 1/10/%0d",
                         g, ok, nok, sum, ref_sum(ops));
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_consecutive();
        test_gaps();
        test_mixed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_group();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
